oscill_nios_hex_display_ctrl: RTL and testbench
===============================================

// Module: oscill_nios_hex_display_ctrl
// PURPOSE
//  Avalon-MM slave driving NUM_DIGITS 7-segment digits from the Nios system. Successor of the single-digit hex PIO:
//  per-digit hex decode or raw segment mode, per-digit blink, global blank, and a time-multiplexed scan output
//  alongside the static per-digit outputs. Sits between the Nios data bus and the board HEX displays.
// PARAMETERS
//  NUM_DIGITS  6           digits driven, 1..8
//  SEG_W       7           segments per digit (no DP)
//  SCAN_DIV    50000       clk cycles per scan slot, >=2
//  BLINK_DIV   25000000    clk cycles per blink half-period, >=2
//  ACTIVE_LOW  1           1: segment lit = 0 on seg_out/scan_seg; scan_sel also active-low
// PORTS
//  clk         in   1                  system clock
//  reset_n     in   1                  async active-low reset
//  address     in   4                  word address
//  chipselect  in   1                  slave select
//  write_n     in   1                  active-low write strobe
//  writedata   in   32                 write data
//  readdata    out  32                 read data, combinational, 0 wait states
//  seg_out     out  NUM_DIGITS*SEG_W   static segments, digit i at [i*SEG_W +: SEG_W]
//  scan_seg    out  SEG_W              segments of currently scanned digit
//  scan_sel    out  NUM_DIGITS         one-hot digit enable for scan_seg
// BEHAVIOUR
//  Reset reset_n, asynchronous, active-low; clock clk. All registers and outputs reset asynchronously.
//  Register map (write = chipselect & ~write_n; unmapped addresses: writes ignored, read 0):
//   0 CTRL  [0] decode_en, [1] blank_all, [2] blink_en; reset 0x2 (display dark)
//   1 VALUE [4*NUM_DIGITS-1:0] one hex nibble per digit, digit0 = [3:0]; reset 0
//   2 BLINK [NUM_DIGITS-1:0] per-digit blink mask; reset 0
//   4+i RAW_i [SEG_W-1:0] raw segment pattern digit i (bit0 = seg a), i < NUM_DIGITS; reset 0
//  Readback returns stored value zero-extended to 32 bits, same cycle as address.
//  Digit pattern: decode_en ? hex_decode(VALUE nibble) : RAW_i; digit dark if blank_all, or blink_en & BLINK[i] & blink_phase.
//  Polarity: ACTIVE_LOW inverts seg_out, scan_seg, scan_sel at output only; registers hold lit=1 form.
//  Latency: write sampled at edge k -> register updated at k -> seg_out reflects it at edge k+1 (outputs registered).
//  Blink: counter 0..BLINK_DIV-1; at wrap blink_phase toggles. Write to CTRL clearing blink_en zeroes counter and phase.
//  Scan: prescaler 0..SCAN_DIV-1; at wrap digit index idx increments, NUM_DIGITS-1 wraps to 0. scan_sel = one-hot(idx),
//   scan_seg = pattern(idx), both registered same edge as idx change; never two sel bits active.
//  Register writes never reset scan or blink counters (except blink clear above); a write coinciding with a scan step
//   shows new data on the new digit at the following edge.
//  Reset mid-operation: idx=0, counters=0, phase=0, outputs immediately dark (all ones when ACTIVE_LOW, sel inactive).
//  NUM_DIGITS*SEG_W and 4*NUM_DIGITS bounds checked at elaboration; out-of-range parameters are a fatal error.
// STRUCTURE
//  Package oscill_hex_pkg: register address constants, CTRL bit indices, 16-entry hex->7-seg table (0..F).
//  Sub-module oscill_hex_seg_decoder: combinational nibble -> SEG_W pattern, one instance per digit plus one for scan.
//  Top holds register file, blink divider, scan divider/index, output registers.
// TESTING (bench with SCAN_DIV=4, BLINK_DIV=8, NUM_DIGITS=6, ACTIVE_LOW=1)
//  1 Reset, no writes -> seg_out all ones, scan_sel=6'h3F, readdata CTRL=0x2, VALUE=0.
//  2 Write VALUE=0x00A3C5, CTRL=0x1 -> seg_out digit0=~7'h6D (5), digit1=~7'h39 (C), digit2=~7'h4F (3), digit3=~7'h77 (A), digits4-5 =~7'h3F (0); one cycle after write.
//  3 CTRL=0x0, RAW_2=0x49 -> digit2 = ~7'h49, others ~RAW_i=7'h7F; read RAW_2 returns 0x49; read addr 3 returns 0.
//  4 CTRL=0x5, BLINK=0x01 -> digit0 toggles dark/lit every 8 cycles, others steady; write CTRL=0x1 -> digit0 lit next edge, phase 0.
//  5 Scan: observe 24 cycles -> scan_sel walks ~000001..~100000 every 4 cycles, wraps to digit0; scan_seg matches seg_out slice.
//  6 Assert reset_n mid-scan at idx=3 during blink -> outputs dark asynchronously; after release scan restarts at digit0.

Source files
------------

// File: rtl/oscill_hex_pkg.sv
// Shared constants for the Nios hex display controller.
//   - Avalon register word addresses
//   - CTRL bit positions and reset value
//   - 16-entry hex -> 7-segment table, lit = 1, bit0 = segment a
package oscill_hex_pkg;

  localparam logic [3:0] ADDR_CTRL  = 4'd0;
  localparam logic [3:0] ADDR_VALUE = 4'd1;
  localparam logic [3:0] ADDR_BLINK = 4'd2;
  localparam logic [3:0] ADDR_RAW0  = 4'd4;

  localparam int CTRL_DECODE_EN = 0;
  localparam int CTRL_BLANK_ALL = 1;
  localparam int CTRL_BLINK_EN  = 2;

  // Power-up state keeps the display dark until software enables it.
  localparam logic [2:0] CTRL_RESET = 3'b010;

  localparam logic [6:0] HEX_SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/oscill_nios_hex_display_ctrl_if.sv
// Avalon-MM bus between the Nios data master and the hex display controller.
//   address    4   word address
//   chipselect 1   slave select
//   write_n    1   active-low write strobe
//   writedata  32  write data
//   readdata   32  combinational read data
// Modports: master (Nios side), slave (display controller side).
interface oscill_nios_hex_display_ctrl_if;

  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/oscill_hex_seg_decoder.sv
// Combinational hex nibble to segment pattern (lit = 1, bit0 = segment a).
//   nibble  in  4      hex digit 0..F
//   seg     out SEG_W  segment pattern, bits above 6 are zero
module oscill_hex_seg_decoder
  import oscill_hex_pkg::*;
#(
  parameter int SEG_W = 7
) (
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] seg
);

  assign seg = SEG_W'(HEX_SEG_TABLE[nibble]);

endmodule

// File: rtl/oscill_nios_hex_display_ctrl.sv
// Avalon-MM slave driving NUM_DIGITS 7-segment digits: per-digit hex decode or
// raw pattern, per-digit blink, global blank, static outputs plus a scanned
// (time-multiplexed) output.
//   clk, reset_n  clock and asynchronous active-low reset
//   bus           Avalon slave port (see oscill_nios_hex_display_ctrl_if)
//   seg_out       static segments, digit i at [i*SEG_W +: SEG_W]
//   scan_seg      segments of the digit currently scanned
//   scan_sel      one-hot digit enable for scan_seg
// Internal patterns are lit = 1; ACTIVE_LOW inverts only at the output flops.
module oscill_nios_hex_display_ctrl
  import oscill_hex_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int SEG_W      = 7,
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_DIV  = 25000000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  oscill_nios_hex_display_ctrl_if.slave bus,
  output logic [NUM_DIGITS*SEG_W-1:0] seg_out,
  output logic [SEG_W-1:0]            scan_seg,
  output logic [NUM_DIGITS-1:0]       scan_sel
);

  localparam int   IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int   PSC_W   = $clog2(SCAN_DIV);
  localparam int   BLK_W   = $clog2(BLINK_DIV);
  localparam logic OFF_BIT = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
    $fatal(1, "NUM_DIGITS must be 1..8 so VALUE fits 32 bits");
  end
  if (SEG_W < 7 || SEG_W > 8) begin : g_bad_seg_w
    $fatal(1, "SEG_W must be 7..8 so NUM_DIGITS*SEG_W stays within 64 bits");
  end
  if (SCAN_DIV < 2 || BLINK_DIV < 2) begin : g_bad_div
    $fatal(1, "SCAN_DIV and BLINK_DIV must be >= 2");
  end

  logic [2:0]              ctrl_r;
  logic [4*NUM_DIGITS-1:0] value_r;
  logic [NUM_DIGITS-1:0]   blink_mask_r;
  logic [SEG_W-1:0]        raw_r [NUM_DIGITS];
  logic [BLK_W-1:0]        blink_cnt_r;
  logic                    blink_phase_r;
  logic [PSC_W-1:0]        psc_r;
  logic [IDX_W-1:0]        idx_r;

  logic                        wr_s;
  logic [3:0]                  raw_idx_s;
  logic                        raw_hit_s;
  logic                        blink_clr_s;
  logic                        scan_wrap_s;
  logic [IDX_W-1:0]            idx_next_s;
  logic [NUM_DIGITS-1:0]       dark_s;
  logic [NUM_DIGITS*SEG_W-1:0] seg_all_s;
  logic [31:0]                 value_ext_s;
  logic [SEG_W-1:0]            scan_dec_s;
  logic [SEG_W-1:0]            scan_pat_s;
  logic                        unused_s;

  assign wr_s        = bus.chipselect & ~bus.write_n;
  assign raw_idx_s   = bus.address - ADDR_RAW0;
  assign raw_hit_s   = (bus.address >= ADDR_RAW0) && ({28'd0, raw_idx_s} < 32'(NUM_DIGITS));
  // Any CTRL write that leaves blink_en low restarts the blink cycle from the lit half.
  assign blink_clr_s = wr_s && (bus.address == ADDR_CTRL) && !bus.writedata[CTRL_BLINK_EN];
  assign scan_wrap_s = (psc_r == PSC_W'(SCAN_DIV - 1));
  assign value_ext_s = 32'(value_r);
  assign unused_s    = ^bus.writedata;

  // Register file writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_r       <= CTRL_RESET;
      value_r      <= {(4*NUM_DIGITS){1'b0}};
      blink_mask_r <= {NUM_DIGITS{1'b0}};
      for (int i = 0; i < NUM_DIGITS; i++) raw_r[i] <= {SEG_W{1'b0}};
    end else if (wr_s) begin
      case (bus.address)
        ADDR_CTRL:  ctrl_r       <= bus.writedata[2:0];
        ADDR_VALUE: value_r      <= bus.writedata[4*NUM_DIGITS-1:0];
        ADDR_BLINK: blink_mask_r <= bus.writedata[NUM_DIGITS-1:0];
        default: begin
          if (raw_hit_s) raw_r[raw_idx_s[IDX_W-1:0]] <= bus.writedata[SEG_W-1:0];
        end
      endcase
    end
  end

  // Combinational zero-wait-state readback; unmapped addresses read zero.
  always_comb begin
    bus.readdata = 32'd0;
    case (bus.address)
      ADDR_CTRL:  bus.readdata = 32'(ctrl_r);
      ADDR_VALUE: bus.readdata = 32'(value_r);
      ADDR_BLINK: bus.readdata = 32'(blink_mask_r);
      default: begin
        if (raw_hit_s) bus.readdata = 32'(raw_r[raw_idx_s[IDX_W-1:0]]);
        else           bus.readdata = 32'd0;
      end
    endcase
  end

  // Blink half-period divider and phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt_r   <= {BLK_W{1'b0}};
      blink_phase_r <= 1'b0;
    end else if (blink_clr_s) begin
      blink_cnt_r   <= {BLK_W{1'b0}};
      blink_phase_r <= 1'b0;
    end else if (blink_cnt_r == BLK_W'(BLINK_DIV - 1)) begin
      blink_cnt_r   <= {BLK_W{1'b0}};
      blink_phase_r <= ~blink_phase_r;
    end else begin
      blink_cnt_r   <= blink_cnt_r + BLK_W'(1);
    end
  end

  // Per-digit pattern: decoded or raw, forced dark by blank or blink.
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    logic [SEG_W-1:0] dec_s;
    oscill_hex_seg_decoder #(.SEG_W(SEG_W)) u_dec (
      .nibble (value_r[4*i +: 4]),
      .seg    (dec_s)
    );
    assign dark_s[i] = ctrl_r[CTRL_BLANK_ALL] |
                       (ctrl_r[CTRL_BLINK_EN] & blink_mask_r[i] & blink_phase_r);
    assign seg_all_s[i*SEG_W +: SEG_W] = dark_s[i] ? {SEG_W{1'b0}} :
                                         (ctrl_r[CTRL_DECODE_EN] ? dec_s : raw_r[i]);
  end

  // Next scan index; advances only when the prescaler wraps.
  always_comb begin
    idx_next_s = idx_r;
    if (scan_wrap_s) begin
      if (idx_r == IDX_W'(NUM_DIGITS - 1)) idx_next_s = {IDX_W{1'b0}};
      else                                 idx_next_s = idx_r + IDX_W'(1);
    end else begin
      idx_next_s = idx_r;
    end
  end

  // The scan path looks at idx_next so sel and seg change on the same edge as idx.
  oscill_hex_seg_decoder #(.SEG_W(SEG_W)) u_scan_dec (
    .nibble (value_ext_s[{idx_next_s, 2'b00} +: 4]),
    .seg    (scan_dec_s)
  );

  // Pattern of the digit about to be scanned.
  always_comb begin
    scan_pat_s = {SEG_W{1'b0}};
    if (dark_s[idx_next_s])               scan_pat_s = {SEG_W{1'b0}};
    else if (ctrl_r[CTRL_DECODE_EN])      scan_pat_s = scan_dec_s;
    else                                  scan_pat_s = raw_r[idx_next_s];
  end

  // Scan prescaler and digit index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      psc_r <= {PSC_W{1'b0}};
      idx_r <= {IDX_W{1'b0}};
    end else begin
      if (scan_wrap_s) psc_r <= {PSC_W{1'b0}};
      else             psc_r <= psc_r + PSC_W'(1);
      idx_r <= idx_next_s;
    end
  end

  // Output flops with polarity applied; reset forces everything dark and deselected.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_out  <= {(NUM_DIGITS*SEG_W){OFF_BIT}};
      scan_seg <= {SEG_W{OFF_BIT}};
      scan_sel <= {NUM_DIGITS{OFF_BIT}};
    end else begin
      seg_out  <= seg_all_s ^ {(NUM_DIGITS*SEG_W){OFF_BIT}};
      scan_seg <= scan_pat_s ^ {SEG_W{OFF_BIT}};
      scan_sel <= (NUM_DIGITS'(1'b1) << idx_next_s) ^ {NUM_DIGITS{OFF_BIT}};
    end
  end

endmodule

// File: tb/tb_oscill_nios_hex_display_ctrl.sv
// Self-checking bench for oscill_nios_hex_display_ctrl (NUM_DIGITS=6,
// SEG_W=7, SCAN_DIV=4, BLINK_DIV=8, ACTIVE_LOW=1). A cycle-level reference
// model computes blink phase and scan digit from elapsed cycle counts.
module tb_oscill_nios_hex_display_ctrl;

  localparam int ND = 6;
  localparam int SW = 7;

  logic          clk;
  logic          reset_n;
  logic [ND*SW-1:0] seg_out;
  logic [SW-1:0] scan_seg;
  logic [ND-1:0] scan_sel;

  oscill_nios_hex_display_ctrl_if bus_if ();

  oscill_nios_hex_display_ctrl #(
    .NUM_DIGITS (ND),
    .SEG_W      (SW),
    .SCAN_DIV   (4),
    .BLINK_DIV  (8),
    .ACTIVE_LOW (1)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus_if.slave),
    .seg_out  (seg_out),
    .scan_seg (scan_seg),
    .scan_sel (scan_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state
  logic [6:0]  hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [2:0]  m_ctrl;
  logic [23:0] m_value;
  logic [5:0]  m_mask;
  logic [6:0]  m_raw [ND];
  int          cyc;
  int          bclr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_ctrl  = 3'b010;
    m_value = 24'd0;
    m_mask  = 6'd0;
    for (int i = 0; i < ND; i++) m_raw[i] = 7'd0;
    cyc  = 0;
    bclr = 0;
  endtask

  function automatic logic [6:0] lit_pat(input int d, input bit ph);
    logic [23:0] sh;
    if (m_ctrl[1] || (m_ctrl[2] && m_mask[d] && ph)) return 7'h00;
    sh = m_value >> (4 * d);
    if (m_ctrl[0]) return hex_tab[int'(sh[3:0])];
    return m_raw[d];
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] a);
    if (a == 4'd0) return {29'd0, m_ctrl};
    if (a == 4'd1) return {8'd0, m_value};
    if (a == 4'd2) return {26'd0, m_mask};
    if (a >= 4'd4 && a <= 4'd9) return {25'd0, m_raw[int'(a) - 4]};
    return 32'd0;
  endfunction

  task automatic model_write(input logic [3:0] a, input logic [31:0] d);
    if (a == 4'd0) begin
      m_ctrl = d[2:0];
      if (!d[2]) bclr = cyc;
    end else if (a == 4'd1) m_value = d[23:0];
    else if (a == 4'd2) m_mask = d[5:0];
    else if (a >= 4'd4 && a <= 4'd9) m_raw[int'(a) - 4] = d[6:0];
  endtask

  // One clock edge: predict outputs from state held before this edge, then
  // apply any write sampled at this edge, then compare.
  task automatic tick();
    logic [ND*SW-1:0] es;
    logic [SW-1:0]    ss;
    logic [ND-1:0]    sl;
    logic [ND-1:0]    one;
    bit ph;
    int idx;
    @(posedge clk);
    cyc++;
    ph = (((cyc - 1 - bclr) / 8) % 2) == 1;
    for (int d = 0; d < ND; d++) es[d*SW +: SW] = ~lit_pat(d, ph);
    idx = (cyc / 4) % ND;
    ss  = ~lit_pat(idx, ph);
    one = 6'b000001;
    sl  = ~(one << idx);
    if (bus_if.chipselect && !bus_if.write_n) model_write(bus_if.address, bus_if.writedata);
    #1;
    check("seg_out", 64'(seg_out), 64'(es));
    check("scan_seg", 64'(scan_seg), 64'(ss));
    check("scan_sel", 64'(scan_sel), 64'(sl));
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus_if.address    = a;
    bus_if.writedata  = d;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    tick();
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
  endtask

  task automatic rd_chk(input logic [3:0] a, input string tag);
    bus_if.address    = a;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b1;
    #1;
    check(tag, 64'(bus_if.readdata), 64'(model_read(a)));
    bus_if.chipselect = 1'b0;
  endtask

  initial begin
    logic [ND*SW-1:0] e_const;
    logic [6:0]       lit0;
    logic [3:0]       ra;
    logic [31:0]      rdv;

    reset_n           = 1'b0;
    bus_if.address    = 4'd0;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = 32'd0;
    model_reset();

    // 1: reset state
    #12;
    e_const = {42{1'b1}};
    check("rst_seg_out", 64'(seg_out), 64'(e_const));
    check("rst_scan_sel", 64'(scan_sel), 64'h3F);
    check("rst_scan_seg", 64'(scan_seg), 64'h7F);
    rd_chk(4'd0, "rst_rd_ctrl");
    rd_chk(4'd1, "rst_rd_value");
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) tick();

    // 2: hex decode
    wr(4'd1, 32'h0000_A3C5);
    wr(4'd0, 32'h0000_0001);
    tick();
    e_const = ~{7'h3F, 7'h3F, 7'h77, 7'h4F, 7'h39, 7'h6D};
    check("decode_const", 64'(seg_out), 64'(e_const));
    rd_chk(4'd1, "rd_value");

    // 3: raw mode
    wr(4'd0, 32'h0000_0000);
    wr(4'd6, 32'h0000_0049);
    tick();
    e_const = {42{1'b1}};
    e_const[14 +: 7] = 7'h36;
    check("raw_const", 64'(seg_out), 64'(e_const));
    rd_chk(4'd6, "rd_raw2");
    rd_chk(4'd3, "rd_unmapped3");
    tick();

    // 4: blink on digit0, then clear
    wr(4'd0, 32'h0000_0005);
    wr(4'd2, 32'h0000_0001);
    repeat (24) tick();
    wr(4'd0, 32'h0000_0001);
    tick();
    lit0 = ~7'h6D;
    check("blink_clear_lit", 64'(seg_out[6:0]), 64'(lit0));

    // 5: scan walk (every tick checks scan_sel/scan_seg)
    wr(4'd2, 32'h0000_0000);
    repeat (24) tick();

    // 6: reset mid-scan at digit 3 during blink
    wr(4'd2, 32'h0000_003F);
    wr(4'd0, 32'h0000_0005);
    for (int k = 0; k < 30; k++) begin
      if (((cyc / 4) % ND) == 3) break;
      tick();
    end
    check("reached_idx3", 64'((cyc / 4) % ND), 64'd3);
    reset_n = 1'b0;
    #1;
    e_const = {42{1'b1}};
    check("async_rst_seg", 64'(seg_out), 64'(e_const));
    check("async_rst_scan_seg", 64'(scan_seg), 64'h7F);
    check("async_rst_scan_sel", 64'(scan_sel), 64'h3F);
    @(posedge clk);
    #1 reset_n = 1'b1;
    model_reset();
    rd_chk(4'd0, "post_rst_ctrl");
    tick();
    check("restart_digit0", 64'(scan_sel), 64'h3E);
    repeat (6) tick();

    // Randomized register traffic against the model
    for (int n = 0; n < 40; n++) begin
      ra  = 4'($urandom_range(0, 11));
      rdv = $urandom;
      if (n % 4 == 0) begin
        ra  = 4'd0;
        rdv = {29'd0, 1'b0 + rdv[2], 1'b0, rdv[0]};
      end
      wr(ra, rdv);
      rd_chk(ra, "rand_readback");
      repeat ($urandom_range(1, 5)) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
